// File: rtl/maq_bcd_cont_if.sv
// Control and digit bus of the two-digit BCD modulo counter.
// master drives the step/load controls, slave (the counter) returns the digits and flags.
interface maq_bcd_cont_if #(
  parameter int MSD_W = 3
);
  logic             maqb_enable;
  logic             maqb_incremento;
  logic             maqb_direcao;
  logic             maqb_load;
  logic [3:0]       maqb_load_Lsd;
  logic [MSD_W-1:0] maqb_load_Msd;
  logic [3:0]       maqb_Lsd;
  logic [MSD_W-1:0] maqb_Msd;
  logic             maqb_carry;
  logic             maqb_borrow;
  logic             maqb_terminal;
  logic             maqb_load_err;

  modport master (
    output maqb_enable, maqb_incremento, maqb_direcao,
    output maqb_load, maqb_load_Lsd, maqb_load_Msd,
    input  maqb_Lsd, maqb_Msd, maqb_carry, maqb_borrow,
    input  maqb_terminal, maqb_load_err
  );

  modport slave (
    input  maqb_enable, maqb_incremento, maqb_direcao,
    input  maqb_load, maqb_load_Lsd, maqb_load_Msd,
    output maqb_Lsd, maqb_Msd, maqb_carry, maqb_borrow,
    output maqb_terminal, maqb_load_err
  );
endinterface

// File: rtl/maq_bcd_cont.sv
// Two-digit BCD up/down modulo counter with checked preload, registered carry/borrow
// pulses and a combinational look-ahead terminal flag for cascading stages.
module maq_bcd_cont #(
  parameter int MODULUS   = 60,
  parameter int RESET_VAL = 0,
  parameter int MSD_W     = 3
) (
  input  logic                 maqb_clock,
  input  logic                 maqb_reset,
  maq_bcd_cont_if.slave        bus
);

  localparam int MAX_VAL = MODULUS - 1;
  localparam logic [3:0]       MAX_L = 4'(MAX_VAL % 10);
  localparam logic [MSD_W-1:0] MAX_M = MSD_W'(MAX_VAL / 10);
  localparam logic [3:0]       RST_L = 4'(RESET_VAL % 10);
  localparam logic [MSD_W-1:0] RST_M = MSD_W'(RESET_VAL / 10);

  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
    $error("maq_bcd_cont: MODULUS must be in 2..100");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("maq_bcd_cont: RESET_VAL must be below MODULUS");
  end
  if (MSD_W < 1 || MSD_W > 8 || (MAX_VAL / 10) >= (1 << MSD_W)) begin : g_bad_msd_w
    $error("maq_bcd_cont: MSD_W cannot hold the tens digit");
  end

  logic [3:0]       r_lsd;
  logic [MSD_W-1:0] r_msd;
  logic             r_carry;
  logic             r_borrow;
  logic             r_load_err;

  logic [3:0]       w_lsd_nx;
  logic [MSD_W-1:0] w_msd_nx;
  logic             w_carry_nx;
  logic             w_borrow_nx;
  logic             w_load_err_nx;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_load_ok;
  int unsigned      w_load_val;

  assign w_at_max   = (r_lsd == MAX_L) && (r_msd == MAX_M);
  assign w_at_zero  = (r_lsd == 4'd0) && (r_msd == '0);
  // Widened so a large MSD_W cannot overflow the range check.
  assign w_load_val = 32'(bus.maqb_load_Msd) * 32'd10 + 32'(bus.maqb_load_Lsd);
  assign w_load_ok  = (bus.maqb_load_Lsd <= 4'd9) && (w_load_val < 32'(MODULUS));

  always_comb begin
    w_lsd_nx      = r_lsd;
    w_msd_nx      = r_msd;
    w_carry_nx    = 1'b0;
    w_borrow_nx   = 1'b0;
    w_load_err_nx = 1'b0;
    if (bus.maqb_load) begin
      if (w_load_ok) begin
        w_lsd_nx = bus.maqb_load_Lsd;
        w_msd_nx = bus.maqb_load_Msd;
      end else begin
        w_load_err_nx = 1'b1;
      end
    end else if (bus.maqb_enable && bus.maqb_incremento) begin
      if (!bus.maqb_direcao) begin
        if (w_at_max) begin
          w_lsd_nx   = 4'd0;
          w_msd_nx   = '0;
          w_carry_nx = 1'b1;
        end else if (r_lsd == 4'd9) begin
          w_lsd_nx = 4'd0;
          w_msd_nx = r_msd + MSD_W'(1);
        end else begin
          w_lsd_nx = r_lsd + 4'd1;
        end
      end else begin
        if (w_at_zero) begin
          w_lsd_nx    = MAX_L;
          w_msd_nx    = MAX_M;
          w_borrow_nx = 1'b1;
        end else if (r_lsd == 4'd0) begin
          w_lsd_nx = 4'd9;
          w_msd_nx = r_msd - MSD_W'(1);
        end else begin
          w_lsd_nx = r_lsd - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge maqb_clock) begin
    if (maqb_reset) begin
      r_lsd      <= RST_L;
      r_msd      <= RST_M;
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_lsd      <= w_lsd_nx;
      r_msd      <= w_msd_nx;
      r_carry    <= w_carry_nx;
      r_borrow   <= w_borrow_nx;
      r_load_err <= w_load_err_nx;
    end
  end

  assign bus.maqb_Lsd      = r_lsd;
  assign bus.maqb_Msd      = r_msd;
  assign bus.maqb_carry    = r_carry;
  assign bus.maqb_borrow   = r_borrow;
  assign bus.maqb_load_err = r_load_err;
  assign bus.maqb_terminal = bus.maqb_direcao ? w_at_zero : w_at_max;

endmodule
